// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe
//   Fixed-modulus Barrett reduction of a double-width product, 4-stage pipe.
//   res = {prod_h, prod_l} mod Q, valid for inputs x < Q^2.
//
//   Stages:
//     S1  x, t = x >> (QW-1)
//     S2  qh = (t * MU) >> (QW+1)
//     S3  r  = x - qh*Q          (0 <= r < 3Q)
//     S4  res = r folded into [0, Q)
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     prod_l, prod_h      low / high half of the product
//     in_valid, in_ready  input handshake (in_ready = !out_valid || out_ready)
//     res, out_valid      reduced result (zero-extended) and its valid
//     out_ready           consumer accepts res
//     range_err           sticky flag: a transferred input had x >= Q^2
//
//   Build option: define BARRETT_RANGE_CHECK_EN to build the input range
//   comparator; otherwise range_err is tied to 0.

module barrett_reduce_pipe #(
    parameter int DATAW = 16,
    parameter int QW    = 14,
    parameter int Q     = 12289,
    parameter int MU    = 21843
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW-1:0] prod_l,
    input  logic [DATAW-1:0] prod_h,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DATAW-1:0] res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             range_err
);

    localparam int XW = 2 * QW;      // used bits of the product
    localparam int TW = QW + 1;      // width of t and of qh
    localparam int RW = QW + 2;      // width of the remainder arithmetic
    localparam int PW = 2 * QW + 3;  // width of t * MU

    logic [2*DATAW-1:0] x_in;
    logic               adv;

    logic               s1_valid_q, s1_valid_d;
    logic [RW-1:0]      s1_x_q,     s1_x_d;
    logic [TW-1:0]      s1_t_q,     s1_t_d;

    logic               s2_valid_q, s2_valid_d;
    logic [RW-1:0]      s2_x_q,     s2_x_d;
    logic [TW-1:0]      s2_qh_q,    s2_qh_d;

    logic               s3_valid_q, s3_valid_d;
    logic [RW-1:0]      s3_r_q,     s3_r_d;

    logic               out_valid_q, out_valid_d;
    logic [DATAW-1:0]   res_q,       res_d;

    logic [RW-1:0]      red;

    assign x_in     = {prod_h, prod_l};
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // Final fold of r (< 3Q) into [0, Q).
    always_comb begin
        red = s3_r_q;
        if (s3_r_q >= RW'(2 * Q)) begin
            red = s3_r_q - RW'(2 * Q);
        end else if (s3_r_q >= RW'(Q)) begin
            red = s3_r_q - RW'(Q);
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_x_d      = s1_x_q;
        s1_t_d      = s1_t_q;
        s2_valid_d  = s2_valid_q;
        s2_x_d      = s2_x_q;
        s2_qh_d     = s2_qh_q;
        s3_valid_d  = s3_valid_q;
        s3_r_d      = s3_r_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;

        if (adv) begin
            s1_valid_d  = in_valid;
            // r = x - qh*Q is known to lie in [0, 3Q), so it can be formed
            // modulo 2^RW; only the low RW bits of x need to travel down.
            s1_x_d      = x_in[RW-1:0];
            s1_t_d      = TW'(x_in[XW-1:0] >> (QW - 1));

            s2_valid_d  = s1_valid_q;
            s2_x_d      = s1_x_q;
            s2_qh_d     = TW'((PW'(s1_t_q) * PW'(MU)) >> (QW + 1));

            s3_valid_d  = s2_valid_q;
            s3_r_d      = s2_x_q - RW'(RW'(s2_qh_q) * RW'(Q));

            out_valid_d = s3_valid_q;
            // Bubbles leave the last result in place rather than garbage.
            if (s3_valid_q) begin
                res_d = DATAW'(red);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_t_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_x_q      <= '0;
            s2_qh_q     <= '0;
            s3_valid_q  <= 1'b0;
            s3_r_q      <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_t_q      <= s1_t_d;
            s2_valid_q  <= s2_valid_d;
            s2_x_q      <= s2_x_d;
            s2_qh_q     <= s2_qh_d;
            s3_valid_q  <= s3_valid_d;
            s3_r_q      <= s3_r_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;

`ifdef BARRETT_RANGE_CHECK_EN
    localparam logic [2*DATAW-1:0] Q_SQ = (2 * DATAW)'(Q) * (2 * DATAW)'(Q);

    logic range_err_q, range_err_d;

    // Full-width compare also catches any nonzero bit above 2*QW.
    always_comb begin
        range_err_d = range_err_q | (in_valid && adv && (x_in >= Q_SQ));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    assign range_err = range_err_q;
`else
    assign range_err = 1'b0;

    // Product bits above 2*QW are intentionally ignored in this build.
    generate
        if (XW < 2 * DATAW) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^x_in[2*DATAW-1:XW];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// tb_barrett_reduce_pipe
//   Directed bench for barrett_reduce_pipe: reset values, basic and maximum
//   legal inputs, backpressure, mid-flight reset, range flag, random soak.

module tb_barrett_reduce_pipe;

    localparam int DATAW = 16;
    localparam int QW    = 14;
    localparam int Q     = 12289;
    localparam int MU    = 21843;

    logic             clk = 1'b0;
    logic             rst;
    logic [DATAW-1:0] prod_l, prod_h;
    logic             in_valid, in_ready;
    logic [DATAW-1:0] res;
    logic             out_valid, out_ready;
    logic             range_err;

    barrett_reduce_pipe #(
        .DATAW (DATAW),
        .QW    (QW),
        .Q     (Q),
        .MU    (MU)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .prod_l    (prod_l),
        .prod_h    (prod_h),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res       (res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    int               errors = 0;
    int               checks = 0;
    int               cyc    = 0;
    int               expq[$];
    int               cycq[$];
    logic             lat_chk   = 1'b0;
    logic             xfer      = 1'b0;
    logic             prev_hold = 1'b0;
    logic [DATAW-1:0] prev_res  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit later.
    // e is the expected result for x, or -1 when the result is unspecified.
    task automatic tick(input logic iv, input logic [31:0] x, input int e,
                        input logic ordy, input logic r);
        int ev, ec;
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        prod_h    = x[31:16];
        prod_l    = x[15:0];
        out_ready = ordy;
        #1;
        xfer = 1'b0;
        if (!r) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || ordy)});
            if (prev_hold) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_res", {16'b0, res}, {16'b0, prev_res});
            end
            if (out_valid && ordy) begin
                if (expq.size() == 0) begin
                    chk("spurious_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    ev = expq.pop_front();
                    ec = cycq.pop_front();
                    if (ev >= 0) chk("res", {16'b0, res}, ev);
                    if (lat_chk) chk("latency", cyc - ec, 32'd4);
                end
            end
            if (iv && in_ready) begin
                expq.push_back(e);
                cycq.push_back(cyc);
                xfer = 1'b1;
            end
            prev_hold = out_valid && !ordy;
        end else begin
            prev_hold = 1'b0;
        end
        prev_res = res;
        cyc++;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && expq.size() > 0; k++) tick(1'b0, 32'd0, -1, 1'b1, 1'b0);
        chk(tag, expq.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] bx[8];
        logic [31:0] px;
        logic        pv;
        int          bi, sent;

        rst = 1'b1; in_valid = 1'b0; prod_l = '0; prod_h = '0; out_ready = 1'b1;

        // Reset for two cycles.
        tick(1'b0, 32'd0, -1, 1'b1, 1'b1);
        tick(1'b0, 32'd0, -1, 1'b1, 1'b1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_res", {16'b0, res}, 32'd0);
        chk("rst_range_err", {31'b0, range_err}, 32'd0);

        // Basic values back-to-back, then maximum legal input (Q-1)^2.
        lat_chk = 1'b1;
        tick(1'b1, 32'd0,         0,     1'b1, 1'b0);
        tick(1'b1, 32'd12289,     0,     1'b1, 1'b0);
        tick(1'b1, 32'd24576,     12287, 1'b1, 1'b0);
        tick(1'b1, 32'd1,         1,     1'b1, 1'b0);
        tick(1'b1, 32'd150994944, 1,     1'b1, 1'b0);
        tick(1'b1, 32'd12288,     12288, 1'b1, 1'b0);
        tick(1'b1, 32'd36866,     12288, 1'b1, 1'b0);
        tick(1'b0, 32'd0,         -1,    1'b1, 1'b0);
        tick(1'b1, 32'd24578,     0,     1'b1, 1'b0);
        drain("drain_basic");
        lat_chk = 1'b0;

        // Backpressure: 8 random products, out_ready low for 5 cycles.
        for (int i = 0; i < 8; i++) bx[i] = $urandom_range(0, Q * Q - 1);
        bi = 0;
        for (int k = 0; k < 40 && bi < 8; k++) begin
            tick(1'b1, bx[bi], int'(bx[bi] % Q), !(k >= 3 && k < 8), 1'b0);
            if (xfer) bi++;
        end
        chk("bp_sent", bi, 32'd8);
        drain("drain_bp");

        // Reset while three inputs are in flight.
        tick(1'b1, 32'd500, 500, 1'b1, 1'b0);
        tick(1'b1, 32'd600, 600, 1'b1, 1'b0);
        tick(1'b1, 32'd700, 700, 1'b1, 1'b0);
        tick(1'b0, 32'd0,   -1,  1'b1, 1'b1);
        expq.delete();
        cycq.delete();
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 32'd0, -1, 1'b1, 1'b0);
            chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        end
        lat_chk = 1'b1;
        tick(1'b1, 32'd100, 100, 1'b1, 1'b0);
        drain("drain_after_rst");
        lat_chk = 1'b0;

        // Random soak with random in_valid and out_ready.
        sent = 0;
        pv   = 1'b0;
        px   = '0;
        for (int k = 0; k < 60000 && sent < 10000; k++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                px = $urandom_range(0, Q * Q - 1);
            end
            tick(pv, px, int'(px % Q), ($urandom_range(0, 3) != 0), 1'b0);
            if (xfer) begin
                sent++;
                pv = 1'b0;
            end
        end
        chk("soak_sent", sent, 32'd10000);
        drain("drain_soak");

        // Range flag: x = Q^2 is the first illegal input.
        chk("range_err_pre", {31'b0, range_err}, 32'd0);
        tick(1'b1, 32'd151019521, -1, 1'b1, 1'b0);
        tick(1'b0, 32'd0, -1, 1'b1, 1'b0);
`ifdef BARRETT_RANGE_CHECK_EN
        chk("range_err_set", {31'b0, range_err}, 32'd1);
`else
        chk("range_err_set", {31'b0, range_err}, 32'd0);
`endif
        drain("drain_range");
        tick(1'b0, 32'd0, -1, 1'b1, 1'b0);
`ifdef BARRETT_RANGE_CHECK_EN
        chk("range_err_sticky", {31'b0, range_err}, 32'd1);
`else
        chk("range_err_sticky", {31'b0, range_err}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
